// File: rtl/ripple_carry_adder_4bit_pkg.sv
// Shared datapath constants for the registered ripple-carry adder.
package ripple_carry_adder_4bit_pkg;

    localparam int unsigned RCA_DEFAULT_WIDTH = 4;

endpackage : ripple_carry_adder_4bit_pkg

// File: rtl/ripple_carry_adder_4bit_full_adder.sv
// Single-bit full adder; one instance per ripple stage.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_half;

    assign w_half = a ^ b;
    assign sum    = w_half ^ cin;
    assign cout   = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/ripple_carry_adder_4bit.sv
// Registered WIDTH-bit ripple-carry adder exposing every stage's carry-out.
module ripple_carry_adder_4bit
    import ripple_carry_adder_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] co,
    output logic             out_valid
);

    // w_carry[i] is the carry into stage i; w_carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_co;
    logic             r_valid;

    assign w_carry[0] = ci;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        full_adder u_fa (
            .a    (ain[gi]),
            .b    (bin[gi]),
            .cin  (w_carry[gi]),
            .sum  (w_sum[gi]),
            .cout (w_carry[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_co    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s  <= w_sum;
                r_co <= w_carry[WIDTH:1];
            end
        end
    end

    assign s         = r_s;
    assign co        = r_co;
    assign out_valid = r_valid;

endmodule : ripple_carry_adder_4bit

// File: tb/tb_ripple_carry_adder_4bit.sv
// Self-checking bench: directed vectors with literal expectations plus randomized traffic against an arithmetic model.
module tb_ripple_carry_adder_4bit;

    localparam int unsigned W = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic         ci       = 1'b0;
    logic [W-1:0] ain      = '0;
    logic [W-1:0] bin      = '0;
    logic [W-1:0] s;
    logic [W-1:0] co;
    logic         out_valid;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Model of the registered outputs, updated once per clock edge.
    logic [W-1:0] m_s  = '0;
    logic [W-1:0] m_co = '0;
    logic         m_v  = 1'b0;

    always #5 clk = ~clk;

    ripple_carry_adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ain       (ain),
        .bin       (bin),
        .ci        (ci),
        .s         (s),
        .co        (co),
        .out_valid (out_valid)
    );

    // Carry out of stage i is whatever overflows when adding the low i+1 bits.
    function automatic logic [2*W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c);
        int unsigned  full;
        int unsigned  part;
        int unsigned  modv;
        logic [W-1:0] carries;
        logic [W-1:0] sum;
        full = 32'(a) + 32'(b) + 32'(c);
        sum  = full[W-1:0];
        for (int unsigned i = 0; i < W; i++) begin
            modv       = 32'd1 << (i + 1);
            part       = (32'(a) % modv) + (32'(b) % modv) + 32'(c);
            carries[i] = (part >= modv);
        end
        return {carries, sum};
    endfunction

    task automatic step(input logic r, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
        rst_n    = r;
        in_valid = v;
        ain      = a;
        bin      = b;
        ci       = c;
        @(posedge clk);
        if (!r) begin
            m_s  = '0;
            m_co = '0;
            m_v  = 1'b0;
        end else begin
            m_v = v;
            if (v) {m_co, m_s} = ref_add(a, b, c);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
            n_total++;
            if ({out_valid, co, s} !== {1'b0, 4'b0000, 4'b0000})
                $display("FAIL reset[%0d]: got v=%b co=%b s=%b want v=0 co=0000 s=0000",
                         i, out_valid, co, s);
            else
                n_pass++;
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [3] = '{4'b0001, 4'b0101, 4'b1001};
        logic [W-1:0] tb [3] = '{4'b0011, 4'b1101, 4'b1100};
        logic         tc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] es [3] = '{4'b0100, 4'b0011, 4'b0101};
        logic [W-1:0] ec [3] = '{4'b0011, 4'b1101, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, ta[i], tb[i], tc[i]);
            n_total++;
            if ({out_valid, co, s} !== {1'b1, ec[i], es[i]})
                $display("FAIL directed[%0d]: got v=%b co=%b s=%b want v=1 co=%b s=%b",
                         i, out_valid, co, s, ec[i], es[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [2] = '{4'b0001, 4'b1010};
        logic [W-1:0] tb [2] = '{4'b0000, 4'b0011};
        logic         tc [2] = '{1'b0, 1'b1};
        logic [W-1:0] es [2] = '{4'b0001, 4'b1110};
        logic [W-1:0] ec [2] = '{4'b0000, 4'b0011};
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, ta[i], tb[i], tc[i]);
            n_total++;
            if ({out_valid, co, s} !== {1'b1, ec[i], es[i]})
                $display("FAIL back_to_back[%0d]: got v=%b co=%b s=%b want v=1 co=%b s=%b",
                         i, out_valid, co, s, ec[i], es[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_hold_and_reset();
        // Follows back_to_back: last result was s=1110, co=0011.
        step(1'b1, 1'b0, 4'b0110, 4'b0111, 1'b1);
        n_total++;
        if ({out_valid, co, s} !== {1'b0, 4'b0011, 4'b1110})
            $display("FAIL hold: got v=%b co=%b s=%b want v=0 co=0011 s=1110",
                     out_valid, co, s);
        else
            n_pass++;

        step(1'b1, 1'b0, 'x, 'x, 1'bx);
        n_total++;
        if ({out_valid, co, s} !== {1'b0, 4'b0011, 4'b1110})
            $display("FAIL hold_x_inputs: got v=%b co=%b s=%b want v=0 co=0011 s=1110",
                     out_valid, co, s);
        else
            n_pass++;

        step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
        n_total++;
        if ({out_valid, co, s} !== {1'b0, 4'b0000, 4'b0000})
            $display("FAIL reset_wins: got v=%b co=%b s=%b want v=0 co=0000 s=0000",
                     out_valid, co, s);
        else
            n_pass++;
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ta [3] = '{4'b1111, 4'b0000, 4'b1111};
        logic [W-1:0] tb [3] = '{4'b1111, 4'b0000, 4'b0000};
        logic         tc [3] = '{1'b1, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{4'b1111, 4'b0000, 4'b0000};
        logic [W-1:0] ec [3] = '{4'b1111, 4'b0000, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, ta[i], tb[i], tc[i]);
            n_total++;
            if ({out_valid, co, s} !== {1'b1, ec[i], es[i]})
                $display("FAIL boundary[%0d]: got v=%b co=%b s=%b want v=1 co=%b s=%b",
                         i, out_valid, co, s, ec[i], es[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        logic r;
        logic v;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) != 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, v, W'($urandom), W'($urandom), 1'($urandom));
            n_total++;
            if ({out_valid, co, s} !== {m_v, m_co, m_s})
                $display("FAIL random[%0d]: got v=%b co=%b s=%b want v=%b co=%b s=%b",
                         i, out_valid, co, s, m_v, m_co, m_s);
            else
                n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold_and_reset();
        test_boundaries();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ripple_carry_adder_4bit

// File: doc/ripple_carry_adder_4bit.md
Name: ripple_carry_adder_4bit

Overview:
- Registered N-bit ripple-carry adder, default 4 bits.
- Adds two operands and a carry-in through a chain of 1-bit full adders.
- Exposes the sum and the full per-stage carry vector; co[WIDTH-1] is the adder carry-out.
- Datapath leaf used wherever a small, clocked, carry-visible adder is needed.

Parameters:
- WIDTH, 4, operand/sum width and number of full-adder stages (legal: 1 to 64).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands on ain/bin/ci are valid this cycle
- ain  input  WIDTH  operand A, unsigned
- bin  input  WIDTH  operand B, unsigned
- ci  input  1  carry-in to stage 0
- s  output  WIDTH  registered sum
- co  output  WIDTH  registered per-stage carry-outs; co[i] = carry out of stage i, co[WIDTH-1] = final carry-out
- out_valid  output  1  s/co hold a result computed from a valid input

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (rst_n), sampled only on the rising edge of clk.
- Reset: while rst_n=0 at a clk edge, s, co and out_valid go to all-zero; no asynchronous path.
- Combinational chain:
  - c[-1]=ci
  - sum_i = ain[i]^bin[i]^c[i-1]
  - c[i] = ain[i]&bin[i] | ain[i]&c[i-1] | bin[i]&c[i-1]
  - strictly rippled, no carry lookahead.
- Arithmetic: {co[WIDTH-1], s} = ain + bin + ci, exact with no overflow loss; unsigned interpretation only.
- Latency:
  - One cycle: result of operands sampled at edge k is visible on s/co after edge k.
  - out_valid follows in_valid with the same one-cycle latency.
- Capture rules:
  - When in_valid=1, s/co load the new result.
  - When in_valid=0, s/co hold their previous value and out_valid drops to 0.
- No back-pressure; a new operation is accepted every cycle (full throughput).
- Boundaries:
  - All-ones + all-ones + ci=1 → s all-ones, co all-ones.
  - All-zero with ci=0 → s=0, co=0.
  - Max carry propagation (ain all-ones, bin=0, ci=1) → s=0, co all-ones.
- Reset mid-operation: reset wins over in_valid in the same cycle; the in-flight result is discarded.
- X on inputs while in_valid=0 must not disturb held outputs.

Decomposition:
- No shared package required.
- Optionally place a default WIDTH localparam in the datapath package if the team has one.
- Natural sub-module: full_adder (inputs a, b, cin; outputs sum, cout), purely combinational, instantiated WIDTH times via generate.
- Top level holds the carry wiring and the output/valid registers.

Test Plan (WIDTH=4; each result checked one cycle after the in_valid=1 edge):
- Reset: hold rst_n=0 for 2 cycles with random inputs and in_valid=1 → s=0000, co=0000, out_valid=0.
- ain=0001, bin=0011, ci=0 → s=0100, co=0011, out_valid=1.
- ain=0101, bin=1101, ci=1 → s=0011, co=1101 (19).
- ain=1001, bin=1100, ci=0 → s=0101, co=1000 (21).
- Two back-to-back operations:
  - ain=0001, bin=0000, ci=0 → s=0001, co=0000.
  - ain=1010, bin=0011, ci=1 → s=1110, co=0011.
- Hold and reset:
  - Drop in_valid → s/co hold 1110/0011, out_valid=0.
  - Then ain=1111, bin=1111, ci=1 with rst_n=0 in the same cycle → all outputs 0.
